axis_vec_coproc: RTL and testbench
==================================

Name: axis_vec_coproc

Overview:
- Parametrised AXI-Stream coprocessor: buffers one input frame of up to NUM_WORDS words, transforms it in place according to a mode, then streams the result out.
- Sits between the DMA MM2S and S2MM streams, in the same slot as the current fixed-function coprocessor.
- Adds over the previous generation: configurable width and depth, short frames terminated by TLAST, four operating modes, and full output backpressure support.

Parameters:
- DATA_WIDTH, 32, stream word width in bits.
- NUM_WORDS, 4, maximum words per frame. Legal values are 2 and above.
- ADDR_WIDTH, $clog2(NUM_WORDS), buffer index width. Derived; do not override.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- MODE  in  2  operation select: 0 pass, 1 reverse, 2 prefix-sum, 3 total.
- S_AXIS_TREADY  out  1  block can accept an input word.
- S_AXIS_TDATA  in  DATA_WIDTH  input word.
- S_AXIS_TLAST  in  1  last word of the input frame.
- S_AXIS_TVALID  in  1  input word valid.
- M_AXIS_TVALID  out  1  output word valid.
- M_AXIS_TDATA  out  DATA_WIDTH  output word.
- M_AXIS_TLAST  out  1  last word of the output frame.
- M_AXIS_TREADY  in  1  downstream can accept an output word.
- BUSY  out  1  high in COMPUTE and WRITE.

Behaviour:
- State machine: IDLE -> READ -> COMPUTE -> WRITE -> READ. The buffer is NUM_WORDS x DATA_WIDTH registers.
- Reset:
  - ARESET high at a clock edge sets the state to IDLE and clears all counters, len, mode_q and sum.
  - Outputs while in reset: S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, BUSY=0.
  - Buffer contents are don't-care.
  - Reset mid-frame in any state discards the frame. No partial output is emitted afterwards.
- IDLE: lasts exactly one cycle, then moves to READ. All outputs are 0.
- READ:
  - S_AXIS_TREADY=1.
  - On each handshake, store TDATA at buf[wr_cnt] and increment wr_cnt.
  - MODE is sampled into mode_q on the first accepted word of the frame only. Later changes to MODE are ignored until the next frame.
  - Exit to COMPUTE after accepting a word with TLAST=1, or after the NUM_WORDS-th word, whichever comes first. len = number of accepted words (1..NUM_WORDS).
  - Words beyond NUM_WORDS without TLAST start a new frame once the block is back in READ.
  - A TLAST on word 1 gives len=1, which is legal.
- COMPUTE:
  - Lasts exactly len cycles. S_AXIS_TREADY=0 and M_AXIS_TVALID=0 throughout. Index i runs 0..len-1.
  - In every mode, sum accumulates buf[i] modulo 2^DATA_WIDTH, starting from 0.
  - Mode 2 only: buf[i] <= buf[i] + buf[i-1] for i>=1, so buf becomes the inclusive prefix sum, wrapping modulo 2^DATA_WIDTH. buf[0] is unchanged.
  - Other modes leave buf untouched.
- WRITE:
  - M_AXIS_TVALID=1. Output index j starts at 0 and advances on each handshake.
  - Modes 0 and 2: TDATA=buf[j]; TLAST=1 when j=len-1.
  - Mode 1: TDATA=buf[len-1-j]; TLAST=1 when j=len-1.
  - Mode 3: a single word, TDATA=sum, TLAST=1.
  - While M_AXIS_TREADY=0, TDATA and TLAST hold stable and TVALID stays high.
  - The handshake on the last word moves the state to READ. S_AXIS_TREADY=1 in the next cycle.
- Latency: with the last input handshake at edge k, M_AXIS_TVALID first rises in the cycle after edge k+len. The input is never accepted while BUSY=1.
- Counters wr_cnt and j are ADDR_WIDTH+1 bits wide, so that len=NUM_WORDS is representable. There is no index wrap-around within a frame.

Test Plan:
- Reset behaviour: hold ARESET for 2 cycles, then release -> all outputs 0 during reset; S_AXIS_TREADY=0 in the IDLE cycle and 1 in the following cycle.
- Pass and reverse: MODE=0, frame 1,2,3,4 (TLAST on 4) -> output 1,2,3,4 with TLAST on 4, first TVALID 4 cycles after the last input edge. Repeat with MODE=1 -> output 4,3,2,1.
- Prefix-sum short frame: MODE=2, frame 5,7 (TLAST on 7) -> len=2, COMPUTE lasts 2 cycles, output 5,12 with TLAST on 12.
- Total with overflow: MODE=3, frame 0xFFFFFFFF,2,0,0 with no TLAST -> frame closes at word 4; single output word 0x00000001 with TLAST=1.
- Backpressure: MODE=0, frame 0xA,0xB,0xC,0xD; toggle M_AXIS_TREADY 1,0,0,1,0,1,1 -> each word held stable while TREADY=0; no loss or duplication; TLAST only on 0xD; MODE changed mid-frame has no effect.
- Reset mid-output: assert ARESET after the first output handshake of a 4-word frame -> TVALID falls in the reset cycle, no remaining words appear, and the next frame 9,8 in MODE=1 outputs 8,9.

Source files
------------

// File: rtl/axis_vec_coproc_if.sv
// AXI-Stream word channel shared by the coprocessor input and output ports.
// The producer uses the master modport, the consumer uses the slave modport.
interface axis_vec_coproc_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] TDATA;
   logic                  TVALID;
   logic                  TREADY;
   logic                  TLAST;

   modport master (output TDATA, output TVALID, output TLAST, input TREADY);
   modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/axis_vec_coproc.sv
// Frame-buffering stream coprocessor: collects up to NUM_WORDS words, applies
// pass / reverse / prefix-sum / total in place, then streams the result out.
module axis_vec_coproc #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 4,
   parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic [1:0]             MODE,
   output logic                   BUSY,
   axis_vec_coproc_if.slave       S_AXIS,
   axis_vec_coproc_if.master      M_AXIS
);

   localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(NUM_WORDS - 1);
   localparam logic [ADDR_WIDTH:0] ONE_CNT  = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      COMPUTE,
      WRITE
   } state_t;

   state_t                r_state;
   state_t                w_nextState;

   logic [DATA_WIDTH-1:0] r_buf [NUM_WORDS];
   logic [ADDR_WIDTH:0]   r_wrCnt;
   logic [ADDR_WIDTH:0]   r_len;
   logic [ADDR_WIDTH:0]   r_idx;
   logic [ADDR_WIDTH:0]   r_outIdx;
   logic [1:0]            r_modeQ;
   logic [DATA_WIDTH-1:0] r_sum;

   logic                  w_sReady;
   logic                  w_mValid;
   logic [DATA_WIDTH-1:0] w_mData;
   logic                  w_mLast;
   logic                  w_busy;
   logic                  w_inFire;
   logic                  w_inLastWord;
   logic                  w_outFire;
   logic                  w_outLast;
   logic [ADDR_WIDTH:0]   w_lenM1;
   logic [ADDR_WIDTH:0]   w_rdIdxWide;
   logic [ADDR_WIDTH:0]   w_prevIdxWide;
   logic [ADDR_WIDTH-1:0] w_wrIdx;
   logic [ADDR_WIDTH-1:0] w_cmpIdx;
   logic [ADDR_WIDTH-1:0] w_prevIdx;
   logic [ADDR_WIDTH-1:0] w_rdIdx;

   assign w_lenM1       = r_len - ONE_CNT;
   assign w_rdIdxWide   = (r_modeQ == 2'd1) ? (w_lenM1 - r_outIdx) : r_outIdx;
   assign w_prevIdxWide = r_idx - ONE_CNT;
   assign w_wrIdx       = r_wrCnt[ADDR_WIDTH-1:0];
   assign w_cmpIdx      = r_idx[ADDR_WIDTH-1:0];
   assign w_prevIdx     = w_prevIdxWide[ADDR_WIDTH-1:0];
   assign w_rdIdx       = w_rdIdxWide[ADDR_WIDTH-1:0];

   assign w_inFire      = S_AXIS.TVALID && w_sReady;
   assign w_inLastWord  = S_AXIS.TLAST || (r_wrCnt == LAST_IDX);
   assign w_outFire     = w_mValid && M_AXIS.TREADY;
   assign w_outLast     = (r_modeQ == 2'd3) || (r_outIdx == w_lenM1);

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    w_nextState = READ;
         READ:    if (w_inFire && w_inLastWord) w_nextState = COMPUTE;
         COMPUTE: if (r_idx == w_lenM1) w_nextState = WRITE;
         WRITE:   if (w_outFire && w_outLast) w_nextState = READ;
         default: w_nextState = IDLE;
      endcase
   end

   // Reset forces every output low immediately, even mid-frame.
   always_comb begin
      w_sReady = 1'b0;
      w_mValid = 1'b0;
      w_mData  = '0;
      w_mLast  = 1'b0;
      w_busy   = 1'b0;
      if (!ARESET) begin
         case (r_state)
            READ:    w_sReady = 1'b1;
            COMPUTE: w_busy   = 1'b1;
            WRITE: begin
               w_busy   = 1'b1;
               w_mValid = 1'b1;
               w_mData  = (r_modeQ == 2'd3) ? r_sum : r_buf[w_rdIdx];
               w_mLast  = w_outLast;
            end
            default: ;
         endcase
      end
   end

   assign S_AXIS.TREADY = w_sReady;
   assign M_AXIS.TVALID = w_mValid;
   assign M_AXIS.TDATA  = w_mData;
   assign M_AXIS.TLAST  = w_mLast;
   assign BUSY          = w_busy;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wrCnt  <= '0;
         r_len    <= '0;
         r_idx    <= '0;
         r_outIdx <= '0;
         r_modeQ  <= '0;
         r_sum    <= '0;
      end else begin
         case (r_state)
            READ: begin
               if (w_inFire) begin
                  if (r_wrCnt == '0) r_modeQ <= MODE;
                  if (w_inLastWord) begin
                     r_len   <= r_wrCnt + ONE_CNT;
                     r_wrCnt <= '0;
                     r_idx   <= '0;
                     r_sum   <= '0;
                  end else begin
                     r_wrCnt <= r_wrCnt + ONE_CNT;
                  end
               end
            end
            COMPUTE: begin
               r_sum <= r_sum + r_buf[w_cmpIdx];
               r_idx <= r_idx + ONE_CNT;
               if (r_idx == w_lenM1) r_outIdx <= '0;
            end
            WRITE: begin
               if (w_outFire) r_outIdx <= r_outIdx + ONE_CNT;
            end
            default: ;
         endcase
      end
   end

   // buf[i-1] already holds its prefix sum when buf[i] is updated.
   always_ff @(posedge ACLK) begin
      if (r_state == READ && w_inFire) begin
         r_buf[w_wrIdx] <= S_AXIS.TDATA;
      end else if (r_state == COMPUTE && r_modeQ == 2'd2 && r_idx != '0) begin
         r_buf[w_cmpIdx] <= r_buf[w_cmpIdx] + r_buf[w_prevIdx];
      end
   end

endmodule

// File: tb/tb_axis_vec_coproc.sv
// Self-checking bench for axis_vec_coproc: directed cases plus random frames
// compared against a frame-level reference model.
module tb_axis_vec_coproc;

   localparam int DW = 32;
   localparam int NW = 4;

   logic         clk;
   logic         ARESET;
   logic [1:0]   MODE;
   logic         BUSY;

   int           testCount = 0;
   int           failCount = 0;
   int           cycleCnt = 0;
   int           lastEdgeCnt = 0;
   int           firstValidCnt = 0;

   logic [DW:0]  expQ[$];

   axis_vec_coproc_if #(.DATA_WIDTH(DW)) sAxis ();
   axis_vec_coproc_if #(.DATA_WIDTH(DW)) mAxis ();

   axis_vec_coproc #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
      .ACLK   (clk),
      .ARESET (ARESET),
      .MODE   (MODE),
      .BUSY   (BUSY),
      .S_AXIS (sAxis),
      .M_AXIS (mAxis)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Frames close on TLAST or at NW words; the first word's MODE rules the frame.
   task automatic modelFrames(input logic [DW-1:0] words[$], input bit lasts[$],
                              input logic [1:0] modes[$], output int count);
      logic [DW-1:0] frame[$];
      logic [1:0]    fMode;
      logic [DW-1:0] acc;
      count = 0;
      for (int i = 0; i < words.size(); i++) begin
         if (frame.size() == 0) fMode = modes[i];
         frame.push_back(words[i]);
         if (lasts[i] || frame.size() == NW) begin
            acc = '0;
            case (fMode)
               2'd0: for (int k = 0; k < frame.size(); k++)
                        expQ.push_back({k == frame.size() - 1, frame[k]});
               2'd1: for (int k = 0; k < frame.size(); k++)
                        expQ.push_back({k == frame.size() - 1, frame[frame.size() - 1 - k]});
               2'd2: for (int k = 0; k < frame.size(); k++) begin
                        acc = acc + frame[k];
                        expQ.push_back({k == frame.size() - 1, acc});
                     end
               default: begin
                  foreach (frame[k]) acc = acc + frame[k];
                  expQ.push_back({1'b1, acc});
               end
            endcase
            count += (fMode == 2'd3) ? 1 : frame.size();
            frame.delete();
         end
      end
   endtask

   task automatic applyStimulus(input logic [DW-1:0] words[$], input bit lasts[$],
                                input logic [1:0] modes[$], input bit gaps);
      int guard;
      for (int i = 0; i < words.size(); i++) begin
         @(negedge clk);
         if (gaps && $urandom_range(3) == 0) begin
            sAxis.TVALID = 1'b0;
            @(negedge clk);
         end
         sAxis.TVALID = 1'b1;
         sAxis.TDATA  = words[i];
         sAxis.TLAST  = lasts[i];
         MODE         = modes[i];
         guard = 0;
         while (!sAxis.TREADY && guard < 300) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 300) begin
            checkOutput("inputTimeout", 0, 1);
            sAxis.TVALID = 1'b0;
            return;
         end
         checkOutput("busyOnAccept", BUSY, 0);
         @(posedge clk);
      end
      @(negedge clk);
      sAxis.TVALID = 1'b0;
      sAxis.TLAST  = 1'b0;
      lastEdgeCnt  = cycleCnt;
   endtask

   task automatic collectOutput(input int n, input bit readyQ[$], input bit randomReady);
      int            got = 0;
      int            guard = 0;
      int            step = 0;
      bit            firstSeen = 0;
      bit            holdValid = 0;
      logic [DW-1:0] heldData = '0;
      logic          heldLast = 1'b0;
      logic [DW:0]   e;
      while (got < n && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (step < readyQ.size()) mAxis.TREADY = readyQ[step];
         else if (randomReady)     mAxis.TREADY = 1'($urandom_range(1));
         else                      mAxis.TREADY = 1'b1;
         if (mAxis.TVALID && !firstSeen) begin
            firstSeen     = 1;
            firstValidCnt = cycleCnt;
         end
         if (holdValid) begin
            checkOutput("holdValid", mAxis.TVALID, 1);
            checkOutput("holdData", mAxis.TDATA, heldData);
            checkOutput("holdLast", mAxis.TLAST, heldLast);
         end
         if (mAxis.TVALID) begin
            step++;
            if (mAxis.TREADY) begin
               holdValid = 0;
               got++;
               if (expQ.size() == 0) begin
                  checkOutput("extraWord", 1, 0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("outData", mAxis.TDATA, e[DW-1:0]);
                  checkOutput("outLast", mAxis.TLAST, e[DW]);
               end
            end else begin
               holdValid = 1;
               heldData  = mAxis.TDATA;
               heldLast  = mAxis.TLAST;
            end
         end
      end
      if (got < n) checkOutput("outputTimeout", got, n);
      @(posedge clk);
      #1 mAxis.TREADY = 1'b0;
   endtask

   task automatic runCase(input logic [DW-1:0] w[$], input bit l[$], input logic [1:0] m[$],
                          input bit pat[$], input bit gaps, input bit randomReady);
      int n;
      modelFrames(w, l, m, n);
      fork
         applyStimulus(w, l, m, gaps);
         collectOutput(n, pat, randomReady);
      join
      checkOutput("leftoverExp", expQ.size(), 0);
      expQ.delete();
   endtask

   initial begin
      logic [DW-1:0] w[$];
      bit            l[$];
      logic [1:0]    m[$];
      bit            noPat[$];
      bit            pat[$];
      int            n;
      int            validSeen;

      ARESET       = 1'b1;
      MODE         = 2'd0;
      sAxis.TVALID = 1'b0;
      sAxis.TDATA  = '0;
      sAxis.TLAST  = 1'b0;
      mAxis.TREADY = 1'b0;

      // Two reset cycles, then one IDLE cycle before READ.
      repeat (2) begin
         @(negedge clk);
         checkOutput("rstSReady", sAxis.TREADY, 0);
         checkOutput("rstMValid", mAxis.TVALID, 0);
         checkOutput("rstMData", mAxis.TDATA, 0);
         checkOutput("rstMLast", mAxis.TLAST, 0);
         checkOutput("rstBusy", BUSY, 0);
      end
      ARESET = 1'b0;
      #1 checkOutput("idleSReady", sAxis.TREADY, 0);
      @(negedge clk);
      checkOutput("readSReady", sAxis.TREADY, 1);

      w = '{32'd1, 32'd2, 32'd3, 32'd4}; l = '{0, 0, 0, 1}; m = '{0, 0, 0, 0};
      runCase(w, l, m, noPat, 0, 0);
      checkOutput("passLatency", firstValidCnt - lastEdgeCnt, 4);

      m = '{1, 1, 1, 1};
      runCase(w, l, m, noPat, 0, 0);
      checkOutput("revLatency", firstValidCnt - lastEdgeCnt, 4);

      w = '{32'd5, 32'd7}; l = '{0, 1}; m = '{2, 2};
      runCase(w, l, m, noPat, 0, 0);
      checkOutput("prefixLatency", firstValidCnt - lastEdgeCnt, 2);

      w = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0}; l = '{0, 0, 0, 0}; m = '{3, 3, 3, 3};
      runCase(w, l, m, noPat, 0, 0);

      w = '{32'hA, 32'hB, 32'hC, 32'hD}; l = '{0, 0, 0, 1}; m = '{0, 3, 1, 2};
      pat = '{1, 0, 0, 1, 0, 1, 1};
      runCase(w, l, m, pat, 0, 0);

      w = '{32'd42}; l = '{1}; m = '{1};
      runCase(w, l, m, noPat, 0, 0);

      // Reset after the first output word: the rest of the frame is discarded.
      w = '{32'd11, 32'd12, 32'd13, 32'd14}; l = '{0, 0, 0, 1}; m = '{0, 0, 0, 0};
      modelFrames(w, l, m, n);
      fork
         applyStimulus(w, l, m, 0);
         collectOutput(1, noPat, 0);
      join
      expQ.delete();
      @(negedge clk);
      ARESET = 1'b1;
      #1 checkOutput("midRstValid", mAxis.TVALID, 0);
      @(negedge clk);
      ARESET = 1'b0;
      mAxis.TREADY = 1'b1;
      validSeen = 0;
      repeat (10) begin
         @(negedge clk);
         if (mAxis.TVALID) validSeen++;
      end
      checkOutput("noPartialOut", validSeen, 0);
      mAxis.TREADY = 1'b0;
      w = '{32'd9, 32'd8}; l = '{0, 1}; m = '{1, 1};
      runCase(w, l, m, noPat, 0, 0);

      // Random frames, including ones closed by word count instead of TLAST.
      for (int t = 0; t < 25; t++) begin
         w.delete(); l.delete(); m.delete();
         for (int f = 0; f < 1 + $urandom_range(2); f++) begin
            int len = 1 + $urandom_range(NW - 1);
            bit noLast = (len == NW) && ($urandom_range(1) == 1);
            for (int k = 0; k < len; k++) begin
               w.push_back(($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + DW'($urandom_range(15))) : DW'($urandom));
               l.push_back((k == len - 1) && !noLast);
               m.push_back(2'($urandom_range(3)));
            end
         end
         runCase(w, l, m, noPat, 1, 1);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
